// File: rtl/io_mac_sequencer.sv
// Bus-master frame engine on the 8-bit isolated-I/O bus: reads a coefficient, polls and
// accumulates N_CH samples times that coefficient, then writes the 24-bit sum MSB-first.
module io_mac_sequencer #(
  parameter int unsigned N_CH       = 3,
  parameter logic [15:0] IN_BASE    = 16'h0100,
  parameter logic [15:0] COEF_ADDR  = 16'h0120,
  parameter logic [15:0] OUT_DATA   = 16'h0140,
  parameter logic [15:0] OUT_STAT   = 16'h0141,
  parameter int unsigned POLL_LIMIT = 0
) (
  input  logic            clock,
  input  logic            reset_,
  output logic [15:0]     addr,
  inout  wire  [7:0]      data,
  output logic            ior_,
  output logic            iow_,
  output logic [N_CH-1:0] miss,
  output logic            frame_done
);

  localparam int unsigned KW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [3:0] {
    StCoef,
    StPoll,
    StRead,
    StNext,
    StOpoll,
    StWr2,
    StWr1,
    StWr0,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [KW-1:0]   k_q, k_d;
  logic [7:0]      poll_q, poll_d;
  logic [7:0]      coef_q, coef_d;
  logic [23:0]     acc_q, acc_d;
  logic [N_CH-1:0] miss_nx_q, miss_nx_d;
  logic [N_CH-1:0] miss_q, miss_d;
  logic [15:0]     addr_q, addr_d;
  logic            ior_q, ior_d;
  logic            iow_q, iow_d;
  logic            drv_q, drv_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            done_q, done_d;

  logic [7:0]      poll_inc;
  logic [15:0]     product;

  assign poll_inc = poll_q + 8'd1;
  assign product  = {8'd0, data} * {8'd0, coef_q};

  // Next-state: read phases 0 (R1) / 1 (R2, sample on exit); write phases 0..3 (W1..W4).
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    k_d       = k_q;
    poll_d    = poll_q;
    coef_d    = coef_q;
    acc_d     = acc_q;
    miss_nx_d = miss_nx_q;
    miss_d    = miss_q;
    unique case (state_q)
      StCoef: begin
        if (phase_q == 2'd0) begin
          phase_d = 2'd1;
        end else if (phase_q == 2'd1) begin
          coef_d  = data;
          k_d     = '0;
          poll_d  = '0;
          phase_d = 2'd0;
          state_d = StPoll;
        end else begin
          // Post-reset slot so the first R1 already carries COEF_ADDR.
          phase_d = 2'd0;
        end
      end
      StPoll: begin
        if (phase_q == 2'd0) begin
          phase_d = 2'd1;
        end else begin
          phase_d = 2'd0;
          poll_d  = poll_inc;
          if (data[0]) begin
            state_d = StRead;
          end else if (POLL_LIMIT != 0 && poll_inc == 8'(POLL_LIMIT)) begin
            miss_nx_d[k_q] = 1'b1;
            state_d        = StNext;
          end
        end
      end
      StRead: begin
        if (phase_q == 2'd0) begin
          phase_d = 2'd1;
        end else begin
          phase_d = 2'd0;
          acc_d   = acc_q + {8'd0, product};
          state_d = StNext;
        end
      end
      StNext: begin
        poll_d = '0;
        if (k_q == KW'(N_CH - 1)) begin
          state_d = StOpoll;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = StPoll;
        end
      end
      StOpoll: begin
        if (phase_q == 2'd0) begin
          phase_d = 2'd1;
        end else begin
          phase_d = 2'd0;
          if (data[0]) begin
            state_d = StWr2;
          end
        end
      end
      StWr2, StWr1, StWr0: begin
        if (phase_q == 2'd3) begin
          phase_d = 2'd0;
          unique case (state_q)
            StWr2:   state_d = StWr1;
            StWr1:   state_d = StWr0;
            default: state_d = StDone;
          endcase
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      StDone: begin
        miss_d    = miss_nx_q;
        miss_nx_d = '0;
        acc_d     = '0;
        phase_d   = 2'd0;
        state_d   = StCoef;
      end
      default: begin
        phase_d = 2'd0;
        state_d = StCoef;
      end
    endcase
  end

  // Bus outputs are a registered decode of the upcoming state/phase.
  always_comb begin
    addr_d  = addr_q;
    ior_d   = 1'b1;
    iow_d   = 1'b1;
    drv_d   = 1'b0;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    unique case (state_d)
      StCoef: begin
        addr_d = COEF_ADDR;
        ior_d  = (phase_d != 2'd1);
      end
      StPoll: begin
        addr_d = IN_BASE + 16'({k_d, 1'b0});
        ior_d  = (phase_d != 2'd1);
      end
      StRead: begin
        addr_d = IN_BASE + 16'({k_d, 1'b1});
        ior_d  = (phase_d != 2'd1);
      end
      StOpoll: begin
        addr_d = OUT_STAT;
        ior_d  = (phase_d != 2'd1);
      end
      StWr2, StWr1, StWr0: begin
        addr_d = OUT_DATA;
        iow_d  = (phase_d != 2'd1);
        drv_d  = (phase_d != 2'd3);
        unique case (state_d)
          StWr2:   wdata_d = acc_d[23:16];
          StWr1:   wdata_d = acc_d[15:8];
          default: wdata_d = acc_d[7:0];
        endcase
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q   <= StCoef;
      phase_q   <= 2'd3;
      k_q       <= '0;
      poll_q    <= '0;
      coef_q    <= '0;
      acc_q     <= '0;
      miss_nx_q <= '0;
      miss_q    <= '0;
      addr_q    <= '0;
      ior_q     <= 1'b1;
      iow_q     <= 1'b1;
      drv_q     <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      k_q       <= k_d;
      poll_q    <= poll_d;
      coef_q    <= coef_d;
      acc_q     <= acc_d;
      miss_nx_q <= miss_nx_d;
      miss_q    <= miss_d;
      addr_q    <= addr_d;
      ior_q     <= ior_d;
      iow_q     <= iow_d;
      drv_q     <= drv_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
    end
  end

  assign data       = drv_q ? wdata_q : 8'bz;
  assign addr       = addr_q;
  assign ior_       = ior_q;
  assign iow_       = iow_q;
  assign miss       = miss_q;
  assign frame_done = done_q;

endmodule

// File: doc/io_mac_sequencer.md
Name: io_mac_sequencer

Overview:
Bus-master controller on the 8-bit isolated-I/O bus (addr/data/ior_/iow_). It generalises the single-input multiply/output sequencer into a parametrised frame engine. Each frame it:
- reads a coefficient;
- polls N_CH input interfaces in order, reading one sample from each and accumulating sample*coefficient;
- waits for the output interface to be ready, then writes the accumulated result MSB-first.
It adds a per-channel poll timeout with sticky miss reporting and a frame-done strobe.

Parameters:
N_CH, 3, number of input channels (1..8)
IN_BASE, 16'h0100, channel k status reg at IN_BASE+2k, data reg at IN_BASE+2k+1
COEF_ADDR, 16'h0120, coefficient register (read once per frame)
OUT_DATA, 16'h0140, output interface data register
OUT_STAT, 16'h0141, output interface status register, bit0=1 means ready
POLL_LIMIT, 0, max status polls per channel before the channel is skipped; 0 = unlimited; max 255

Ports:
clock  input  1  system clock, all state on rising edge
reset_  input  1  asynchronous, active-low reset
addr  output  16  I/O address, registered
data  inout  8  I/O data bus; driven only during write transactions, else high-Z
ior_  output  1  active-low I/O read strobe, registered
iow_  output  1  active-low I/O write strobe, registered
miss  output  N_CH  per-channel skip flags of the last completed frame
frame_done  output  1  one-clock pulse after the last result byte of a frame is written

Behaviour:
- Reset (reset_=0, asynchronous):
  - outputs: ior_=1, iow_=1, data high-Z, addr=16'h0000, miss=0, frame_done=0;
  - internals: accumulator=0, coefficient=0, channel index=0, poll counter=0;
  - FSM goes to COEF.
  - Asserting reset mid-transaction aborts it immediately, with strobes high and bus released. After release, operation restarts from COEF.
- Read transaction, 2 clocks:
  - R1: addr<=target, ior_ stays 1.
  - R2: ior_<=0.
  - On the edge ending R2, data is sampled and ior_<=1.
  - ior_ is low exactly one clock; addr is stable throughout.
- Write transaction, 4 clocks:
  - W1: addr<=target, data driven.
  - W2: iow_<=0.
  - W3: iow_<=1.
  - W4: bus released.
  - Data is valid from W1 through W3.
- Bus invariants:
  - ior_ and iow_ are never low together.
  - data is never driven while ior_=0.
- FSM (each read/write step is one full transaction):
  - COEF: read COEF_ADDR into A. Set k=0 and clear the poll counter -> POLL.
  - POLL: read IN_BASE+2k and increment the poll counter.
    - If bit0=1 -> READ.
    - Else, if POLL_LIMIT!=0 and counter==POLL_LIMIT: set miss_next[k], add nothing -> NEXT.
    - Else -> POLL (same k).
  - READ: read IN_BASE+2k+1, then acc <= acc + data*A -> NEXT.
  - NEXT: clear the poll counter.
    - If k==N_CH-1 -> OPOLL.
    - Else k <= k+1 -> POLL.
  - OPOLL: read OUT_STAT, repeating until bit0=1 (no timeout) -> WR2.
  - WR2, WR1, WR0: write acc[23:16], acc[15:8], acc[7:0] to OUT_DATA, in that order.
  - DONE, one clock: frame_done=1, miss<=miss_next, clear acc and miss_next -> COEF.
- Arithmetic:
  - The product is 8x8 unsigned, giving 16 bits.
  - The accumulator is 24 bits unsigned. It cannot overflow for N_CH<=8, since the max is 8*0xFE01 < 2^19.
  - Bytes are zero-extended.
- Other timing rules:
  - The coefficient is re-read every frame. A change takes effect from the next frame only.
  - miss updates only in DONE and holds between frames.

Test Plan:
- Basic frame, N_CH=3, coef=0x05, samples 0x10/0x20/0x30 with immediately-ready status -> reads 0x0120, 0x0100, 0x0101, 0x0102, 0x0103, 0x0104, 0x0105, 0x0141; writes 0x00, 0x01, 0xE0 to 0x0140; frame_done pulses once; miss=3'b000.
- Max values, coef=0xFF, samples 0xFF x3 -> writes 0x02, 0xFA, 0x03.
- Timeout, POLL_LIMIT=4, channel 1 status always 0, coef=0x02, samples 0x01/-/0x03 -> exactly 4 reads of 0x0102 and no read of 0x0103; output 0x00, 0x00, 0x08; miss=3'b010 after frame_done; miss clears after a clean next frame.
- Output backpressure, OUT_STAT bit0=0 for 10 polls -> 10 extra reads of 0x0141, no iow_ activity, then 3 writes after ready.
- Reset during W2 of the second result byte (iow_=0) -> iow_=1 and data=Z within the reset assertion time, no further writes; after release the first transaction is a read of 0x0120.
- Protocol monitor over all tests:
  - ior_ and iow_ never both 0;
  - each strobe low exactly one clock;
  - addr stable while any strobe is low;
  - data high-Z whenever ior_=0.
